ps2_receiver: RTL

Front end of the keyboard path. Synchronises the raw PS/2 clock/data pins, deframes 11-bit device-to-host frames, and buffers received scan-code bytes in a small FIFO. Presents each byte to the downstream display/decode stage as an 8-bit value qualified by a one-cycle `ps2dis_recFlag` pulse.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_fifo.sv | 64 ++++++
 rtl/ps2_receiver.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path.
package ps2_pkg;

  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;

  // Break prefix; the display stage uses it to tell key releases from presses.
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } ps2_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO for received scan codes. Depth is 2**FIFO_AW.
// A push into a full FIFO is dropped even if a pop happens in the same cycle,
// because fullness is judged on the occupancy before the pop.
import ps2_pkg::*;

module ps2_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [7:0]         wdata_i,
  input  logic               pop_i,
  output logic [7:0]         rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit frame deframer,
// byte FIFO and a paced pop interface toward the display/decode stage.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity;
// otherwise only the stop bit qualifies a frame.
//
// state | meaning
// IDLE  | waiting for a falling PS/2 clock edge with data low (start bit)
// RECV  | shifting data/parity/stop bits, timeout armed between edges
// DONE  | one cycle: validate frame, push byte or flag error/overflow
import ps2_pkg::*;

module ps2_receiver #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             ps2dis_ready,
  input  logic             clr_err,
  output logic [7:0]       ps2dis_data,
  output logic             ps2dis_recFlag,
  output logic             frame_err,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic [2:0]   clk_s_q, data_s_q;
  ps2_state_e   state_q, state_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [9:0]   shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]   data_q;
  logic         recflag_q;
  logic         frame_err_q, frame_err_d;
  logic         overflow_q;

  logic         fall, data_bit;
  logic         frame_ok, parity_ok;
  logic         push, pop, ovf_set;
  logic         fifo_full, fifo_empty;
  logic [7:0]   fifo_rdata;

  assign fall      = clk_s_q[2] & ~clk_s_q[1];
  assign data_bit  = data_s_q[1];
  // After ten shifts: [7:0] data, [8] parity, [9] stop.
  assign parity_ok = ^shift_q[8:0];
  assign frame_ok  = shift_q[9] & (parity_ok | ~PARITY_EN);

  // Pop pacing: never on two consecutive cycles, so every pulse is isolated.
  assign pop = ~fifo_empty & ps2dis_ready & ~recflag_q;

  assign ps2dis_recFlag = pop;
  assign ps2dis_data    = pop ? fifo_rdata : data_q;
  assign frame_err      = frame_err_q;
  assign overflow       = overflow_q;

  // Three-flop synchronisers on both raw pins; idle level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s_q  <= 3'b111;
      data_s_q <= 3'b111;
    end else begin
      clk_s_q  <= {clk_s_q[1:0], ps2_clk};
      data_s_q <= {data_s_q[1:0], ps2_data};
    end
  end

  // Deframer next-state, timeout down-counter and DONE-cycle decisions.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    timer_d     = timer_q;
    push        = 1'b0;
    ovf_set     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall && !data_bit) begin
          shift_d   = '0;
          bit_cnt_d = 4'd1;
          timer_d   = TIMER_LOAD;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          shift_d   = {data_bit, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = TIMER_LOAD;
          if (bit_cnt_q == LAST_BIT) state_d = DONE;
        end else if (timer_q == '0) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!frame_ok)      frame_err_d = 1'b1;
        else if (fifo_full) ovf_set     = 1'b1;
        else                push        = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Deframer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
    end
  end

  // Output-side registers: held byte, pop history, error pulse, sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q      <= 8'h00;
      recflag_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (pop) data_q <= fifo_rdata;
      recflag_q   <= pop;
      frame_err_q <= frame_err_d;
      if (ovf_set)      overflow_q <= 1'b1;
      else if (clr_err) overflow_q <= 1'b0;
    end
  end

  ps2_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (shift_q[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
